// File: rtl/ysyx_23060332_seq.sv
// Multi-cycle sequencer for the NPC core: IDLE -> FETCH -> DECODE -> [MEM] -> WB.
// It halts on ebreak, an invalid instruction or a bus timeout.
// Optional cycle/instret counters are enabled by `define YSYX_23060332_PERF_EN.
module ysyx_23060332_seq #(
    parameter int MEM_TIMEOUT = 1023,
    parameter int CNT_W       = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       ifu_req,
    input  logic       ifu_rvalid,
    output logic       inst_latch,
    input  logic       dec_is_load,
    input  logic       dec_is_store,
    input  logic       dec_is_jump,
    input  logic       dec_ebreak,
    input  logic       dec_invalid,
    output logic       lsu_req,
    output logic       lsu_we,
    input  logic       lsu_done,
    output logic       rf_wen_en,
    output logic       pc_we,
    output logic       pc_sel,
    output logic       halted,
    output logic [1:0] halt_code,
    output logic [2:0] state_o
`ifdef YSYX_23060332_PERF_EN
    ,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [1:0] HC_EBREAK  = 2'b01;
    localparam logic [1:0] HC_INVALID = 2'b10;
    localparam logic [1:0] HC_TIMEOUT = 2'b11;

    logic [2:0]       state, state_next;
    logic [1:0]       code_next;
    logic [CNT_W-1:0] tmo_cnt;
    logic             timeout;
    logic             store_q, jump_q;

    assign timeout = (tmo_cnt == CNT_W'(MEM_TIMEOUT));

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        code_next  = halt_code;
        case (state)
            S_IDLE:  state_next = S_FETCH;
            S_FETCH: begin
                // A response on the limit cycle wins over the timeout.
                if (ifu_rvalid) begin
                    state_next = S_DECODE;
                end else if (timeout) begin
                    state_next = S_HALT;
                    code_next  = HC_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (dec_invalid || (dec_is_load && dec_is_store)) begin
                    state_next = S_HALT;
                    code_next  = HC_INVALID;
                end else if (dec_ebreak) begin
                    state_next = S_HALT;
                    code_next  = HC_EBREAK;
                end else if (dec_is_load || dec_is_store) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                if (lsu_done) begin
                    state_next = S_WB;
                end else if (timeout) begin
                    state_next = S_HALT;
                    code_next  = HC_TIMEOUT;
                end
            end
            S_WB:    state_next = S_FETCH;
            S_HALT:  state_next = S_HALT;
            default: begin
                state_next = S_HALT;
                code_next  = HC_INVALID;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            halt_code <= 2'b00;
            tmo_cnt   <= '0;
            store_q   <= 1'b0;
            jump_q    <= 1'b0;
        end else begin
            state     <= state_next;
            halt_code <= code_next;
            // Counter restarts on every state change, so it is zero on FETCH/MEM entry.
            if (state_next != state) begin
                tmo_cnt <= '0;
            end else if (state == S_FETCH || state == S_MEM) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
            if (state == S_DECODE) begin
                store_q <= dec_is_store;
                jump_q  <= dec_is_jump;
            end
        end
    end

    assign ifu_req    = (state == S_FETCH);
    assign inst_latch = (state == S_FETCH) & ifu_rvalid;
    assign lsu_req    = (state == S_MEM);
    assign lsu_we     = (state == S_MEM) & store_q;
    assign pc_we      = (state == S_WB);
    assign rf_wen_en  = (state == S_WB) & ~store_q;
    assign pc_sel     = (state == S_WB) & jump_q;
    assign halted     = (state == S_HALT);
    assign state_o    = state;

`ifdef YSYX_23060332_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state == S_FETCH || state == S_DECODE || state == S_MEM || state == S_WB) begin
                cycle_cnt <= cycle_cnt + 64'd1;
            end
            if (state == S_WB) begin
                instret_cnt <= instret_cnt + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_23060332_seq.sv
// Directed bench for ysyx_23060332_seq with MEM_TIMEOUT=4 and hand-computed expectations.
module tb_ysyx_23060332_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ifu_req, ifu_rvalid, inst_latch;
    logic       dec_is_load, dec_is_store, dec_is_jump, dec_ebreak, dec_invalid;
    logic       lsu_req, lsu_we, lsu_done;
    logic       rf_wen_en, pc_we, pc_sel, halted;
    logic [1:0] halt_code;
    logic [2:0] state_o;
`ifdef YSYX_23060332_PERF_EN
    logic [63:0] cycle_cnt, instret_cnt;
`endif

    int compared = 0;
    int mismatched = 0;

    ysyx_23060332_seq #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req(ifu_req), .ifu_rvalid(ifu_rvalid), .inst_latch(inst_latch),
        .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_is_jump(dec_is_jump),
        .dec_ebreak(dec_ebreak), .dec_invalid(dec_invalid),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_done(lsu_done),
        .rf_wen_en(rf_wen_en), .pc_we(pc_we), .pc_sel(pc_sel),
        .halted(halted), .halt_code(halt_code), .state_o(state_o)
`ifdef YSYX_23060332_PERF_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_rvalid   = 1'b0;
        dec_is_load  = 1'b0;
        dec_is_store = 1'b0;
        dec_is_jump  = 1'b0;
        dec_ebreak   = 1'b0;
        dec_invalid  = 1'b0;
        lsu_done     = 1'b0;
    endtask

    // Reset for two edges, release; the DUT then sits in IDLE for one cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ifu_req"}, {63'd0, ifu_req}, 64'd0);
        check({tag, "_lsu_req"}, {63'd0, lsu_req}, 64'd0);
        check({tag, "_pc_we"}, {63'd0, pc_we}, 64'd0);
        check({tag, "_rf_wen"}, {63'd0, rf_wen_en}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        do_reset();

        // Reset / IDLE
        check("rst_state", {61'd0, state_o}, 64'd0);
        check("rst_code", {62'd0, halt_code}, 64'd0);
        check("rst_halted", {63'd0, halted}, 64'd0);
        check_quiet("rst");

        // ALU: rvalid on third FETCH cycle
        tick();
        check("alu_f1_state", {61'd0, state_o}, 64'd1);
        check("alu_f1_ifu_req", {63'd0, ifu_req}, 64'd1);
        check("alu_f1_latch", {63'd0, inst_latch}, 64'd0);
        tick();
        check("alu_f2_state", {61'd0, state_o}, 64'd1);
        tick();
        ifu_rvalid = 1'b1;
        #1;
        check("alu_f3_latch", {63'd0, inst_latch}, 64'd1);
        tick();
        ifu_rvalid = 1'b0;
        check("alu_dec_state", {61'd0, state_o}, 64'd2);
        check("alu_dec_ifu_req", {63'd0, ifu_req}, 64'd0);
        tick();
        check("alu_wb_state", {61'd0, state_o}, 64'd4);
        check("alu_wb_pc_we", {63'd0, pc_we}, 64'd1);
        check("alu_wb_rf_wen", {63'd0, rf_wen_en}, 64'd1);
        check("alu_wb_pc_sel", {63'd0, pc_sel}, 64'd0);
        check("alu_wb_ifu_req", {63'd0, ifu_req}, 64'd0);
        tick();
        check("alu_refetch", {61'd0, state_o}, 64'd1);

        // Load: immediate fetch, lsu_done on third MEM cycle; stray ifu_rvalid in MEM ignored
        ifu_rvalid = 1'b1;
        tick();
        ifu_rvalid = 1'b0;
        dec_is_load = 1'b1;
        check("ld_dec_state", {61'd0, state_o}, 64'd2);
        tick();
        dec_is_load = 1'b0;
        ifu_rvalid = 1'b1;
        check("ld_m1_state", {61'd0, state_o}, 64'd3);
        check("ld_m1_lsu_req", {63'd0, lsu_req}, 64'd1);
        check("ld_m1_lsu_we", {63'd0, lsu_we}, 64'd0);
        check("ld_m1_latch", {63'd0, inst_latch}, 64'd0);
        tick();
        ifu_rvalid = 1'b0;
        check("ld_m2_state", {61'd0, state_o}, 64'd3);
        check("ld_m2_lsu_req", {63'd0, lsu_req}, 64'd1);
        tick();
        lsu_done = 1'b1;
        check("ld_m3_lsu_req", {63'd0, lsu_req}, 64'd1);
        tick();
        lsu_done = 1'b0;
        check("ld_wb_state", {61'd0, state_o}, 64'd4);
        check("ld_wb_rf_wen", {63'd0, rf_wen_en}, 64'd1);
        check("ld_wb_lsu_req", {63'd0, lsu_req}, 64'd0);
        tick();

        // Store: immediate fetch and immediate lsu_done
        ifu_rvalid = 1'b1;
        tick();
        ifu_rvalid = 1'b0;
        dec_is_store = 1'b1;
        tick();
        dec_is_store = 1'b0;
        lsu_done = 1'b1;
        check("st_mem_state", {61'd0, state_o}, 64'd3);
        check("st_mem_lsu_we", {63'd0, lsu_we}, 64'd1);
        tick();
        lsu_done = 1'b0;
        check("st_wb_pc_we", {63'd0, pc_we}, 64'd1);
        check("st_wb_rf_wen", {63'd0, rf_wen_en}, 64'd0);
        check("st_wb_lsu_we", {63'd0, lsu_we}, 64'd0);
        tick();

        // Jump
        ifu_rvalid = 1'b1;
        tick();
        ifu_rvalid = 1'b0;
        dec_is_jump = 1'b1;
        tick();
        dec_is_jump = 1'b0;
        check("jmp_wb_state", {61'd0, state_o}, 64'd4);
        check("jmp_wb_pc_we", {63'd0, pc_we}, 64'd1);
        check("jmp_wb_pc_sel", {63'd0, pc_sel}, 64'd1);
        check("jmp_wb_rf_wen", {63'd0, rf_wen_en}, 64'd1);
        tick();

        // Response on the limit cycle (fifth FETCH cycle) wins
        for (int i = 0; i < 4; i++) tick();
        check("lim_f5_state", {61'd0, state_o}, 64'd1);
        ifu_rvalid = 1'b1;
        tick();
        ifu_rvalid = 1'b0;
        check("lim_dec_state", {61'd0, state_o}, 64'd2);
        check("lim_no_halt", {63'd0, halted}, 64'd0);

        // Fetch timeout: no rvalid for five FETCH cycles
        do_reset();
        tick();
        for (int i = 0; i < 4; i++) tick();
        check("tmo_f5_state", {61'd0, state_o}, 64'd1);
        tick();
        check("tmo_state", {61'd0, state_o}, 64'd5);
        check("tmo_halted", {63'd0, halted}, 64'd1);
        check("tmo_code", {62'd0, halt_code}, 64'd3);
        check_quiet("tmo");

        // ebreak
        do_reset();
        tick();
        ifu_rvalid = 1'b1;
        tick();
        ifu_rvalid = 1'b0;
        dec_ebreak = 1'b1;
        tick();
        dec_ebreak = 1'b0;
        ifu_rvalid = 1'b1;
        check("ebk_halted", {63'd0, halted}, 64'd1);
        check("ebk_code", {62'd0, halt_code}, 64'd1);
        tick();
        tick();
        check("ebk_hold_state", {61'd0, state_o}, 64'd5);
        check("ebk_hold_code", {62'd0, halt_code}, 64'd1);
        check_quiet("ebk_hold");
        ifu_rvalid = 1'b0;

        // invalid beats ebreak
        do_reset();
        tick();
        ifu_rvalid = 1'b1;
        tick();
        ifu_rvalid = 1'b0;
        dec_invalid = 1'b1;
        dec_ebreak = 1'b1;
        tick();
        clear_inputs();
        check("inv_state", {61'd0, state_o}, 64'd5);
        check("inv_code", {62'd0, halt_code}, 64'd2);

        // load and store both set is invalid
        do_reset();
        tick();
        ifu_rvalid = 1'b1;
        tick();
        ifu_rvalid = 1'b0;
        dec_is_load = 1'b1;
        dec_is_store = 1'b1;
        tick();
        clear_inputs();
        check("ldst_code", {62'd0, halt_code}, 64'd2);
        check("ldst_lsu_req", {63'd0, lsu_req}, 64'd0);

        // Reset during second MEM cycle aborts the access
        do_reset();
        tick();
        ifu_rvalid = 1'b1;
        tick();
        ifu_rvalid = 1'b0;
        dec_is_load = 1'b1;
        tick();
        dec_is_load = 1'b0;
        tick();
        check("abort_m2_lsu_req", {63'd0, lsu_req}, 64'd1);
        rst_n = 1'b0;
        lsu_done = 1'b1;
        tick();
        check("abort_state", {61'd0, state_o}, 64'd0);
        check("abort_code", {62'd0, halt_code}, 64'd0);
        check_quiet("abort");
`ifdef YSYX_23060332_PERF_EN
        check("abort_cycle_cnt", cycle_cnt, 64'd0);
        check("abort_instret_cnt", instret_cnt, 64'd0);
`endif
        rst_n = 1'b1;
        lsu_done = 1'b0;
        tick();
        check("abort_restart", {61'd0, state_o}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
